axil_master_arbiter: RTL and testbench

Shares the single AXI-Lite register slave (15-bit address, 32-bit data) between two masters: M0 is the USB command handler and M1 is the on-chip sequencer. One transaction is in flight at a time, read or write, locked from address phase to response. Round-robin grant between masters; within one master, a write wins over a read.

---
 rtl/axil_arb_pkg.sv | 30 +++
 rtl/axil_master_arbiter_if.sv | 26 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/axil_master_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_axil_master_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-master AXI-Lite arbiter.
// Provides bus widths, response codes, the FSM state encoding, the timeout
// limit/fill pattern and a small one-hot grant helper.
package axil_arb_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TO_W   = 24;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [TO_W-1:0]   TIMEOUT_LIMIT = {TO_W{1'b1}};
    localparam logic [DATA_W-1:0] DEADBEEF      = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_e;

    // One-hot grant vector for a 1-bit owner index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axil_master_arbiter_if.sv
// AXI-Lite bundle for N ports, fields packed port-major (port i at [i*W +: W]).
// Modport master: drives address/data/valid/bready/rready.
// Modport slave:  drives ready/bvalid/bresp/rvalid/rdata/rresp.
interface axil_master_arbiter_if #(parameter int unsigned N = 1);
    import axil_arb_pkg::*;

    logic [N*ADDR_W-1:0] awaddr;
    logic [N*ADDR_W-1:0] araddr;
    logic [N*DATA_W-1:0] wdata;
    logic [N*DATA_W-1:0] rdata;
    logic [N*STRB_W-1:0] wstrb;
    logic [N-1:0]        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [N-1:0]        arvalid, arready, rvalid, rready;
    logic [2*N-1:0]      bresp, rresp;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker.
// Ports: clk, rstn; req[1:0] requests; en commits the pick into last_owner;
// winner_c index of the chosen requester; any_c asserted when any request is up.
// last_owner resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       en,
    output logic       winner_c,
    output logic       any_c
);

    logic last_owner_q, last_owner_d;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        any_c        = |req;
        winner_c     = (req == 2'b11) ? ~last_owner_q : req[1];
        last_owner_d = last_owner_q;
        if (en && any_c) begin
            last_owner_d = winner_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one AXI-Lite slave between M0 (USB command handler) and M1 (sequencer).
// One transaction in flight, locked from address phase to response; round-robin
// between masters, write before read within a master.
// Ports: clk, rstn (async, active-low); m = both masters (slave modport);
// s = downstream slave (master modport); grant = one-hot owner, 0 when idle.
// Optional ARB_TIMEOUT_EN: 24-bit stall counter answers the owner with SLVERR.
module axil_master_arbiter
    import axil_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    axil_master_arbiter_if.slave  m,
    axil_master_arbiter_if.master s,
    output logic [1:0]           grant
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [1:0] grant_q, grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] wr_req_c, rd_req_c;
    logic       winner_c, any_c, arb_en_c;

    assign wr_req_c = m.awvalid & m.wvalid;
    assign rd_req_c = m.arvalid;
    assign grant    = grant_q;

`ifdef ARB_TIMEOUT_EN
    logic            to_pend_q, to_pend_d;
    logic            to_rd_q, to_rd_d;
    logic            to_own_q, to_own_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_fire_c;

    assign to_fire_c = (state_q != ST_IDLE) && (to_cnt_q == TIMEOUT_LIMIT);
    // Hold off new grants until the owner has taken its error response.
    assign arb_en_c  = (state_q == ST_IDLE) && !to_pend_q;
`else
    assign arb_en_c  = (state_q == ST_IDLE);
`endif

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rstn     (rstn),
        .req      (wr_req_c | rd_req_c),
        .en       (arb_en_c),
        .winner_c (winner_c),
        .any_c    (any_c)
    );

    // Next-state, owner and AW/W completion tracking.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en_c && any_c) begin
                    owner_d = winner_c;
                    grant_d = onehot2(winner_c);
                    state_d = wr_req_c[winner_c] ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                aw_done_d = aw_done_q | (s.awvalid & s.awready);
                w_done_d  = w_done_q  | (s.wvalid  & s.wready);
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                if (s.bvalid && s.bready) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end
            end
            ST_RD_ADDR: begin
                if (s.arvalid && s.arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (s.rvalid && s.rready) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
`ifdef ARB_TIMEOUT_EN
        to_pend_d = to_pend_q;
        to_rd_d   = to_rd_q;
        to_own_d  = to_own_q;
        if (to_pend_q && (to_rd_q ? m.rready[to_own_q] : m.bready[to_own_q])) begin
            to_pend_d = 1'b0;
        end
        if (to_fire_c) begin
            state_d   = ST_IDLE;
            grant_d   = 2'b00;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            to_pend_d = 1'b1;
            to_rd_d   = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
            to_own_d  = owner_q;
        end
        to_cnt_d = ((state_q == ST_IDLE) || (state_d != state_q)) ? '0 : to_cnt_q + TO_W'(1);
`endif
    end

    // Channel routing from the registered owner; everything else reads as 0.
    always_comb begin
        s.awaddr  = '0;
        s.awvalid = 1'b0;
        s.wdata   = '0;
        s.wstrb   = '0;
        s.wvalid  = 1'b0;
        s.bready  = 1'b0;
        s.araddr  = '0;
        s.arvalid = 1'b0;
        s.rready  = 1'b0;
        m.awready = '0;
        m.wready  = '0;
        m.bvalid  = '0;
        m.bresp   = '0;
        m.arready = '0;
        m.rvalid  = '0;
        m.rdata   = '0;
        m.rresp   = '0;
        for (int i = 0; i < 2; i++) begin
            if (owner_q == 1'(i)) begin
                case (state_q)
                    ST_WR_ADDR: begin
                        s.awaddr     = m.awaddr[i*ADDR_W +: ADDR_W];
                        s.awvalid    = m.awvalid[i] & ~aw_done_q;
                        s.wdata      = m.wdata[i*DATA_W +: DATA_W];
                        s.wstrb      = m.wstrb[i*STRB_W +: STRB_W];
                        s.wvalid     = m.wvalid[i] & ~w_done_q;
                        m.awready[i] = s.awready & ~aw_done_q;
                        m.wready[i]  = s.wready & ~w_done_q;
                    end
                    ST_WR_RESP: begin
                        s.bready          = m.bready[i];
                        m.bvalid[i]       = s.bvalid;
                        m.bresp[2*i +: 2] = s.bresp;
                    end
                    ST_RD_ADDR: begin
                        s.araddr     = m.araddr[i*ADDR_W +: ADDR_W];
                        s.arvalid    = m.arvalid[i];
                        m.arready[i] = s.arready;
                    end
                    ST_RD_DATA: begin
                        s.rready                  = m.rready[i];
                        m.rvalid[i]               = s.rvalid;
                        m.rdata[i*DATA_W +: DATA_W] = s.rdata;
                        m.rresp[2*i +: 2]         = s.rresp;
                    end
                    default: ;
                endcase
            end
        end
`ifdef ARB_TIMEOUT_EN
        // The expiring cycle must not complete a late slave handshake.
        if (to_fire_c) begin
            s.awvalid = 1'b0;
            s.wvalid  = 1'b0;
            s.arvalid = 1'b0;
            s.bready  = 1'b0;
            s.rready  = 1'b0;
            m.awready = '0;
            m.wready  = '0;
            m.bvalid  = '0;
            m.arready = '0;
            m.rvalid  = '0;
        end
        for (int i = 0; i < 2; i++) begin
            if (to_pend_q && (to_own_q == 1'(i))) begin
                if (to_rd_q) begin
                    m.rvalid[i]                 = 1'b1;
                    m.rdata[i*DATA_W +: DATA_W] = DEADBEEF;
                    m.rresp[2*i +: 2]           = RESP_SLVERR;
                end else begin
                    m.bvalid[i]       = 1'b1;
                    m.bresp[2*i +: 2] = RESP_SLVERR;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_pend_q <= 1'b0;
            to_rd_q   <= 1'b0;
            to_own_q  <= 1'b0;
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef ARB_TIMEOUT_EN
            to_pend_q <= to_pend_d;
            to_rd_q   <= to_rd_d;
            to_own_q  <= to_own_d;
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    // Legal-master assumption: the owner holds valid until its beat is accepted.
    a_ar_hold: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_RD_ADDR && !s.arready) |=> (state_q != ST_RD_ADDR || m.arvalid[owner_q]));
    a_aw_hold: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_WR_ADDR && !aw_done_q && !s.awready)
        |=> (state_q != ST_WR_ADDR || aw_done_q || m.awvalid[owner_q]));
    a_w_hold: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_WR_ADDR && !w_done_q && !s.wready)
        |=> (state_q != ST_WR_ADDR || w_done_q || m.wvalid[owner_q]));

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter: two driven masters, a behavioural slave.
module tb_axil_master_arbiter;
    import axil_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] grant;
    logic [1:0] bresp_cfg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axil_master_arbiter_if #(.N(2)) mif ();
    axil_master_arbiter_if #(.N(1)) sif ();

    axil_master_arbiter dut (
        .clk   (clk),
        .rstn  (rstn),
        .m     (mif),
        .s     (sif),
        .grant (grant)
    );

    // Behavioural slave: B one cycle after both AW and W seen, R one cycle after AR.
    logic              aw_got, w_got, aw_fire, w_fire;
    int                aw_cnt = 0;
    int                w_cnt  = 0;
    logic [ADDR_W-1:0] last_awaddr;
    logic [DATA_W-1:0] last_wdata;

    assign aw_fire = sif.awvalid & sif.awready;
    assign w_fire  = sif.wvalid & sif.wready;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sif.bvalid <= 1'b0;
            sif.bresp  <= 2'b00;
            sif.rvalid <= 1'b0;
            sif.rdata  <= '0;
            sif.rresp  <= 2'b00;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_cnt      <= aw_cnt + 1;
                last_awaddr <= sif.awaddr;
            end
            if (w_fire) begin
                w_cnt      <= w_cnt + 1;
                last_wdata <= sif.wdata;
            end
            if (sif.bvalid && sif.bready) sif.bvalid <= 1'b0;
            if ((aw_got | aw_fire) && (w_got | w_fire) && !sif.bvalid) begin
                sif.bvalid <= 1'b1;
                sif.bresp  <= bresp_cfg;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                aw_got <= aw_got | aw_fire;
                w_got  <= w_got | w_fire;
            end
            if (sif.rvalid && sif.rready) sif.rvalid <= 1'b0;
            if (sif.arvalid && sif.arready) begin
                sif.rvalid <= 1'b1;
                sif.rdata  <= 32'hA500_0000 | 32'(sif.araddr);
                sif.rresp  <= 2'b00;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int aw0;
        int w0;
        logic exp_m;

        rstn          = 1'b0;
        bresp_cfg     = 2'b00;
        mif.awaddr    = '0;
        mif.araddr    = '0;
        mif.wdata     = '0;
        mif.wstrb     = '0;
        mif.awvalid   = '0;
        mif.wvalid    = '0;
        mif.arvalid   = '0;
        mif.bready    = 2'b11;
        mif.rready    = 2'b11;
        sif.awready   = 1'b1;
        sif.wready    = 1'b1;
        sif.arready   = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s_valids", 64'({sif.awvalid, sif.wvalid, sif.arvalid, sif.bready, sif.rready}), 64'd0);
        chk("rst_s_addr", 64'({sif.awaddr, sif.araddr}), 64'd0);
        chk("rst_m_ready", 64'({mif.awready, mif.wready, mif.arready, mif.bvalid, mif.rvalid}), 64'd0);
        rstn = 1'b1;
        tick();

        // T1: M0 single write, zero-wait slave.
        mif.awaddr[14:0] = 15'h0010;
        mif.wdata[31:0]  = 32'h1234_5678;
        mif.wstrb[3:0]   = 4'hF;
        mif.awvalid[0]   = 1'b1;
        mif.wvalid[0]    = 1'b1;
        chk("t1_grant_pre", 64'(grant), 64'd0);
        tick();
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_s_awvalid", 64'(sif.awvalid), 64'd1);
        chk("t1_s_awaddr", 64'(sif.awaddr), 64'h10);
        chk("t1_s_wdata", 64'(sif.wdata), 64'h1234_5678);
        chk("t1_m_awready", 64'(mif.awready), 64'h1);
        tick();
        chk("t1_bvalid", 64'(mif.bvalid), 64'h1);
        chk("t1_bresp", 64'(mif.bresp), 64'h0);
        chk("t1_s_awvalid_low", 64'(sif.awvalid), 64'd0);
        chk("t1_aw_cnt", 64'(aw_cnt), 64'd1);
        chk("t1_w_cnt", 64'(w_cnt), 64'd1);
        mif.awvalid[0] = 1'b0;
        mif.wvalid[0]  = 1'b0;
        tick();
        chk("t1_grant_idle", 64'(grant), 64'd0);
        chk("t1_bvalid_done", 64'(mif.bvalid), 64'd0);

        // T2: both masters read continuously; M0 owned last, so M1 first.
        mif.araddr  = {15'h0200, 15'h0100};
        mif.arvalid = 2'b11;
        exp_m = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            tick();
            if (|mif.rvalid) begin
                chk("t2_grant", 64'(grant), 64'(onehot2(exp_m)));
                chk("t2_rvalid", 64'(mif.rvalid), 64'(onehot2(exp_m)));
                chk("t2_rdata", mif.rdata, exp_m ? {32'hA500_0200, 32'h0} : {32'h0, 32'hA500_0100});
                n++;
                exp_m = ~exp_m;
            end
        end
        mif.arvalid = 2'b00;
        chk("t2_count", 64'(n), 64'd8);
        tick();

        // T3: awready well ahead of wready; exactly one AW and one W beat.
        sif.wready       = 1'b0;
        aw0              = aw_cnt;
        w0               = w_cnt;
        mif.awaddr[14:0] = 15'h0024;
        mif.wdata[31:0]  = 32'hCAFE_F00D;
        mif.awvalid[0]   = 1'b1;
        mif.wvalid[0]    = 1'b1;
        tick();
        chk("t3_grant", 64'(grant), 64'h1);
        chk("t3_s_awvalid", 64'(sif.awvalid), 64'd1);
        tick();
        chk("t3_awvalid_masked", 64'(sif.awvalid), 64'd0);
        chk("t3_wvalid_held", 64'(sif.wvalid), 64'd1);
        chk("t3_awready_masked", 64'(mif.awready), 64'd0);
        mif.awvalid[0] = 1'b0;
        tick();
        chk("t3_awvalid_masked2", 64'(sif.awvalid), 64'd0);
        tick();
        chk("t3_aw_once_early", 64'(aw_cnt - aw0), 64'd1);
        chk("t3_w_none_yet", 64'(w_cnt - w0), 64'd0);
        sif.wready = 1'b1;
        tick();
        chk("t3_bvalid", 64'(mif.bvalid), 64'h1);
        chk("t3_aw_once", 64'(aw_cnt - aw0), 64'd1);
        chk("t3_w_once", 64'(w_cnt - w0), 64'd1);
        chk("t3_wdata", 64'(last_wdata), 64'hCAFE_F00D);
        mif.wvalid[0] = 1'b0;
        tick();
        chk("t3_grant_idle", 64'(grant), 64'd0);

        // T4: M1 write+read with M0 read; M1 write first, SLVERR passed through.
        bresp_cfg          = 2'b10;
        mif.awaddr[29:15]  = 15'h0044;
        mif.wdata[63:32]   = 32'h0BAD_F00D;
        mif.wstrb[7:4]     = 4'hF;
        mif.araddr         = {15'h0300, 15'h0104};
        mif.awvalid[1]     = 1'b1;
        mif.wvalid[1]      = 1'b1;
        mif.arvalid        = 2'b11;
        tick();
        chk("t4_grant_m1", 64'(grant), 64'h2);
        chk("t4_s_awvalid", 64'(sif.awvalid), 64'd1);
        chk("t4_s_arvalid", 64'(sif.arvalid), 64'd0);
        chk("t4_s_awaddr", 64'(sif.awaddr), 64'h44);
        tick();
        chk("t4_bvalid", 64'(mif.bvalid), 64'h2);
        chk("t4_bresp", 64'(mif.bresp), 64'h8);
        mif.awvalid[1] = 1'b0;
        mif.wvalid[1]  = 1'b0;
        tick();
        chk("t4_idle", 64'(grant), 64'd0);
        tick();
        chk("t4_grant_m0", 64'(grant), 64'h1);
        chk("t4_s_araddr_m0", 64'(sif.araddr), 64'h104);
        tick();
        chk("t4_rvalid_m0", 64'(mif.rvalid), 64'h1);
        chk("t4_rdata_m0", mif.rdata, {32'h0, 32'hA500_0104});
        mif.arvalid[0] = 1'b0;
        tick();
        tick();
        chk("t4_grant_m1_rd", 64'(grant), 64'h2);
        chk("t4_s_araddr_m1", 64'(sif.araddr), 64'h300);
        tick();
        chk("t4_rvalid_m1", 64'(mif.rvalid), 64'h2);
        chk("t4_rdata_m1", mif.rdata, {32'hA500_0300, 32'h0});
        mif.arvalid[1] = 1'b0;
        bresp_cfg      = 2'b00;
        tick();

        // T5: reset while M0 sits in the data phase, then a fresh tie.
        mif.rready[0]     = 1'b0;
        mif.araddr[14:0]  = 15'h0108;
        mif.arvalid[0]    = 1'b1;
        tick();
        chk("t5_grant", 64'(grant), 64'h1);
        tick();
        chk("t5_rvalid", 64'(mif.rvalid), 64'h1);
        mif.arvalid[0] = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_grant", 64'(grant), 64'd0);
        chk("t5_rst_rvalid", 64'(mif.rvalid), 64'd0);
        chk("t5_rst_rdata", mif.rdata, 64'd0);
        chk("t5_rst_s", 64'({sif.rready, sif.arvalid, sif.araddr}), 64'd0);
        #2;
        rstn          = 1'b1;
        mif.rready[0] = 1'b1;
        mif.araddr    = {15'h020C, 15'h010C};
        mif.arvalid   = 2'b11;
        tick();
        chk("t5_m0_first", 64'(grant), 64'h1);
        tick();
        chk("t5_rdata_m0", mif.rdata, {32'h0, 32'hA500_010C});
        mif.arvalid[0] = 1'b0;
        tick();
        tick();
        chk("t5_m1_next", 64'(grant), 64'h2);
        tick();
        chk("t5_rdata_m1", mif.rdata, {32'hA500_020C, 32'h0});
        mif.arvalid[1] = 1'b0;
        tick();
        chk("t5_idle", 64'(grant), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
